// File: rtl/device_bus_router.sv
// rtl/device_bus_router.sv - single-master, N-slave device bus router
// Decodes a core request against an ID table, strobes one slave, and returns its data or an error.
module device_bus_router #(
  parameter int                 XLEN    = 32,
  parameter int                 N_DEV   = 4,
  parameter logic [N_DEV*4-1:0] DEV_IDS = {4'h6, 4'h4, 4'h2, 4'h0},
  parameter logic [1:0]         REGION  = 2'b11,
  parameter int                 TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  S_DEVICE_strobe_i,
  input  logic [XLEN-1:0]       S_DEVICE_addr_i,
  input  logic                  S_DEVICE_rw_i,
  input  logic [XLEN/8-1:0]     S_DEVICE_byte_enable_i,
  input  logic [XLEN-1:0]       S_DEVICE_data_i,
  output logic                  S_DEVICE_data_ready_o,
  output logic [XLEN-1:0]       S_DEVICE_data_o,
  output logic                  S_DEVICE_error_o,
  output logic [N_DEV-1:0]      M_strobe_o,
  output logic [XLEN-1:0]       M_addr_o,
  output logic                  M_rw_o,
  output logic [XLEN/8-1:0]     M_byte_enable_o,
  output logic [XLEN-1:0]       M_data_o,
  input  logic [N_DEV-1:0]      M_data_ready_i,
  input  logic [N_DEV*XLEN-1:0] M_data_i,
  output logic [7:0]            err_count_o
);

  localparam int SW = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  // The WAIT counter holds (cycle number - 1), so the last chance is at TIMEOUT-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state, state_n;
  logic [SW-1:0]       sel, sel_n, hit_sel;
  logic                hit;
  logic [CW-1:0]       cnt, cnt_n;
  logic [XLEN-1:0]     m_addr, m_addr_n, m_data, m_data_n, rdata, rdata_n;
  logic                m_rw, m_rw_n;
  logic [XLEN/8-1:0]   m_be, m_be_n;
  logic [N_DEV-1:0]    strobe, strobe_n;
  logic                ready, ready_n, err, err_n;
  logic [7:0]          err_cnt, err_cnt_n;
  logic                sel_ready;
  logic [XLEN-1:0]     sel_data;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Scan from the top slot down so the lowest matching slot is the one kept.
  always_comb begin
    hit     = 1'b0;
    hit_sel = '0;
    for (int k = N_DEV - 1; k >= 0; k--) begin
      if (S_DEVICE_addr_i[31:30] == REGION && S_DEVICE_addr_i[27:24] == DEV_IDS[4*k +: 4]) begin
        hit     = 1'b1;
        hit_sel = SW'(k);
      end
    end
  end

  assign sel_ready = M_data_ready_i[sel];
  assign sel_data  = M_data_i[XLEN*sel +: XLEN];

  always_comb begin
    state_n   = state;
    sel_n     = sel;
    cnt_n     = cnt;
    m_addr_n  = m_addr;
    m_rw_n    = m_rw;
    m_be_n    = m_be;
    m_data_n  = m_data;
    rdata_n   = rdata;
    strobe_n  = '0;
    ready_n   = 1'b0;
    err_n     = 1'b0;
    err_cnt_n = err_cnt;
    case (state)
      IDLE: begin
        if (S_DEVICE_strobe_i) begin
          m_addr_n = S_DEVICE_addr_i;
          m_rw_n   = S_DEVICE_rw_i;
          m_be_n   = S_DEVICE_byte_enable_i;
          m_data_n = S_DEVICE_data_i;
          if (hit) begin
            sel_n    = hit_sel;
            strobe_n = N_DEV'(1) << hit_sel;
            state_n  = ISSUE;
          end else begin
            ready_n   = 1'b1;
            err_n     = 1'b1;
            rdata_n   = '0;
            err_cnt_n = sat_inc(err_cnt);
            state_n   = RESP;
          end
        end
      end
      ISSUE: begin
        cnt_n = CW'(1);
        if (sel_ready) begin
          ready_n = 1'b1;
          rdata_n = sel_data;
          state_n = RESP;
        end else if (TIMEOUT == 1) begin
          ready_n   = 1'b1;
          err_n     = 1'b1;
          rdata_n   = '0;
          err_cnt_n = sat_inc(err_cnt);
          state_n   = RESP;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (sel_ready) begin
          ready_n = 1'b1;
          rdata_n = sel_data;
          state_n = RESP;
        end else if (cnt == CNT_LAST) begin
          ready_n   = 1'b1;
          err_n     = 1'b1;
          rdata_n   = '0;
          err_cnt_n = sat_inc(err_cnt);
          state_n   = RESP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      cnt     <= '0;
      m_addr  <= '0;
      m_rw    <= 1'b0;
      m_be    <= '0;
      m_data  <= '0;
      rdata   <= '0;
      strobe  <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      cnt     <= cnt_n;
      m_addr  <= m_addr_n;
      m_rw    <= m_rw_n;
      m_be    <= m_be_n;
      m_data  <= m_data_n;
      rdata   <= rdata_n;
      strobe  <= strobe_n;
      ready   <= ready_n;
      err     <= err_n;
      err_cnt <= err_cnt_n;
    end
  end

  assign S_DEVICE_data_ready_o = ready;
  assign S_DEVICE_error_o      = err;
  assign S_DEVICE_data_o       = rdata;
  assign M_strobe_o            = strobe;
  assign M_addr_o              = m_addr;
  assign M_rw_o                = m_rw;
  assign M_byte_enable_o       = m_be;
  assign M_data_o              = m_data;
  assign err_count_o           = err_cnt;

endmodule

// File: tb/tb_device_bus_router.sv
// tb/tb_device_bus_router.sv - directed self-checking bench for device_bus_router
module tb_device_bus_router;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         S_DEVICE_strobe_i;
  logic [31:0]  S_DEVICE_addr_i;
  logic         S_DEVICE_rw_i;
  logic [3:0]   S_DEVICE_byte_enable_i;
  logic [31:0]  S_DEVICE_data_i;
  logic         S_DEVICE_data_ready_o;
  logic [31:0]  S_DEVICE_data_o;
  logic         S_DEVICE_error_o;
  logic [3:0]   M_strobe_o;
  logic [31:0]  M_addr_o;
  logic         M_rw_o;
  logic [3:0]   M_byte_enable_o;
  logic [31:0]  M_data_o;
  logic [3:0]   M_data_ready_i;
  logic [127:0] M_data_i;
  logic [7:0]   err_count_o;

  int total = 0;
  int bad   = 0;

  device_bus_router dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .S_DEVICE_strobe_i      (S_DEVICE_strobe_i),
    .S_DEVICE_addr_i        (S_DEVICE_addr_i),
    .S_DEVICE_rw_i          (S_DEVICE_rw_i),
    .S_DEVICE_byte_enable_i (S_DEVICE_byte_enable_i),
    .S_DEVICE_data_i        (S_DEVICE_data_i),
    .S_DEVICE_data_ready_o  (S_DEVICE_data_ready_o),
    .S_DEVICE_data_o        (S_DEVICE_data_o),
    .S_DEVICE_error_o       (S_DEVICE_error_o),
    .M_strobe_o             (M_strobe_o),
    .M_addr_o               (M_addr_o),
    .M_rw_o                 (M_rw_o),
    .M_byte_enable_o        (M_byte_enable_o),
    .M_data_o               (M_data_o),
    .M_data_ready_i         (M_data_ready_i),
    .M_data_i               (M_data_i),
    .err_count_o            (err_count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ready"}, S_DEVICE_data_ready_o, 0);
    check({tag, ".error"}, S_DEVICE_error_o, 0);
    check({tag, ".rdata"}, S_DEVICE_data_o, 0);
    check({tag, ".mstrobe"}, M_strobe_o, 0);
    check({tag, ".mbus"}, {M_addr_o, M_rw_o, M_byte_enable_o, M_data_o}, 0);
    check({tag, ".errcnt"}, err_count_o, 0);
  endtask

  // Cycle 0 is the strobe cycle; rslv answers in cycle 1+d (rslv<0 or d<0: silent).
  // Returns with the bench sitting in the idle cycle after the response.
  task automatic txn(input logic [31:0] addr, input logic rw, input logic [3:0] be,
                     input logic [31:0] wd, input int rslv, input int d, input logic [31:0] rd,
                     input bit noise, output int rcyc, output logic rerr, output logic [31:0] rdat,
                     output logic [3:0] strb1, output bit stable, output int extra);
    int cyc;
    S_DEVICE_addr_i        = addr;
    S_DEVICE_rw_i          = rw;
    S_DEVICE_byte_enable_i = be;
    S_DEVICE_data_i        = wd;
    S_DEVICE_strobe_i      = 1'b1;
    tick();
    S_DEVICE_strobe_i = 1'b0;
    cyc    = 1;
    strb1  = M_strobe_o;
    stable = 1'b1;
    extra  = 0;
    rcyc   = -1;
    rerr   = 1'bx;
    rdat   = 'x;
    while (cyc < 400) begin
      if (S_DEVICE_data_ready_o) begin
        rcyc = cyc;
        rerr = S_DEVICE_error_o;
        rdat = S_DEVICE_data_o;
        break;
      end
      if ({M_addr_o, M_rw_o, M_byte_enable_o, M_data_o} !== {addr, rw, be, wd}) stable = 1'b0;
      if (cyc >= 2 && M_strobe_o != 0) extra++;
      M_data_ready_i    = '0;
      S_DEVICE_strobe_i = 1'b0;
      if (rslv >= 0 && d >= 0 && cyc == 1 + d) begin
        M_data_ready_i[rslv]    = 1'b1;
        M_data_i[32*rslv +: 32] = rd;
      end
      if (noise && cyc >= 2 && cyc <= 4) begin
        M_data_ready_i    = M_data_ready_i | 4'b1001;
        S_DEVICE_strobe_i = 1'b1;
        S_DEVICE_addr_i   = 32'hC000_0000;
      end
      tick();
      cyc++;
    end
    M_data_ready_i    = '0;
    S_DEVICE_strobe_i = 1'b0;
    tick();
  endtask

  int          rcyc, extra, cnt;
  logic        rerr;
  logic [31:0] rdat;
  logic [3:0]  strb1;
  bit          stable;

  initial begin
    rst_n                  = 1'b0;
    S_DEVICE_strobe_i      = 1'b0;
    S_DEVICE_addr_i        = '0;
    S_DEVICE_rw_i          = 1'b0;
    S_DEVICE_byte_enable_i = '0;
    S_DEVICE_data_i        = '0;
    M_data_ready_i         = '0;
    M_data_i               = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hAAAA_0000};
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    txn(32'hC200_0004, 1'b0, 4'hF, 32'h0, 1, 0, 32'h1234_5678, 0, rcyc, rerr, rdat, strb1, stable, extra);
    check("rd1.strobe", strb1, 4'b0010);
    check("rd1.cycle", rcyc, 2);
    check("rd1.error", rerr, 1'b0);
    check("rd1.data", rdat, 32'h1234_5678);
    check("rd1.mbus", stable, 1'b1);

    txn(32'hC000_0000, 1'b1, 4'hF, 32'hA5A5_A5A5, 0, 3, 32'h0BAD_F00D, 0, rcyc, rerr, rdat, strb1, stable, extra);
    check("wr0.strobe", strb1, 4'b0001);
    check("wr0.mbus", stable, 1'b1);
    check("wr0.mrw", M_rw_o, 1'b1);
    check("wr0.cycle", rcyc, 5);
    check("wr0.error", rerr, 1'b0);
    check("wr0.data", rdat, 32'h0BAD_F00D);
    check("wr0.errcnt", err_count_o, 0);

    txn(32'hC500_0000, 1'b0, 4'h3, 32'h0, -1, -1, 32'h0, 0, rcyc, rerr, rdat, strb1, stable, extra);
    check("miss1.strobe", {strb1, 28'(extra)}, 0);
    check("miss1.cycle", rcyc, 1);
    check("miss1.error", rerr, 1'b1);
    check("miss1.data", rdat, 0);
    check("miss1.errcnt", err_count_o, 1);

    txn(32'h8000_0000, 1'b0, 4'h1, 32'h0, -1, -1, 32'h0, 0, rcyc, rerr, rdat, strb1, stable, extra);
    check("miss2.strobe", {strb1, 28'(extra)}, 0);
    check("miss2.cycle", rcyc, 1);
    check("miss2.error", rerr, 1'b1);
    check("miss2.data", rdat, 0);
    check("miss2.errcnt", err_count_o, 2);

    txn(32'hC400_0000, 1'b0, 4'hF, 32'h0, -1, -1, 32'h0, 0, rcyc, rerr, rdat, strb1, stable, extra);
    check("tmo.strobe", strb1, 4'b0100);
    check("tmo.cycle", rcyc, 256);
    check("tmo.error", rerr, 1'b1);
    check("tmo.data", rdat, 0);
    check("tmo.errcnt", err_count_o, 3);
    // Bench now sits in cycle 257; slave 2 answers late in cycle 258.
    tick();
    M_data_ready_i[2] = 1'b1;
    tick();
    M_data_ready_i = '0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (S_DEVICE_data_ready_o || M_strobe_o != 0) cnt++;
      tick();
    end
    check("late.ignored", cnt, 0);
    check("late.errcnt", err_count_o, 3);

    txn(32'hC400_0000, 1'b0, 4'hF, 32'h0, 2, 254, 32'h5555_0255, 0, rcyc, rerr, rdat, strb1, stable, extra);
    check("edge.cycle", rcyc, 256);
    check("edge.error", rerr, 1'b0);
    check("edge.data", rdat, 32'h5555_0255);
    check("edge.errcnt", err_count_o, 3);

    txn(32'hC400_0010, 1'b0, 4'h7, 32'h0, 2, 6, 32'h2222_BEEF, 1, rcyc, rerr, rdat, strb1, stable, extra);
    check("noise.strobe", strb1, 4'b0100);
    check("noise.extra", extra, 0);
    check("noise.mbus", stable, 1'b1);
    check("noise.cycle", rcyc, 8);
    check("noise.error", rerr, 1'b0);
    check("noise.data", rdat, 32'h2222_BEEF);

    S_DEVICE_addr_i   = 32'hC400_0000;
    S_DEVICE_strobe_i = 1'b1;
    tick();
    S_DEVICE_strobe_i = 1'b0;
    check("rstw.strobe", M_strobe_o, 4'b0100);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_all_zero("rstw");
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (S_DEVICE_data_ready_o || M_strobe_o != 0) cnt++;
      tick();
    end
    check("rstw.silent", cnt, 0);

    for (int i = 0; i < 256; i++) begin
      txn(32'hC100_0000, 1'b0, 4'h1, 32'h0, -1, -1, 32'h0, 0, rcyc, rerr, rdat, strb1, stable, extra);
      if (i == 0) check("sat.first", err_count_o, 1);
      if (i == 254) check("sat.reach", err_count_o, 255);
    end
    check("sat.hold", err_count_o, 255);
    check("sat.error", rerr, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
